// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared FSM states, MMIO offsets and default memory map for mem_bus_ctrl
package mem_map_pkg;
  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;
  localparam logic [3:0] LED_OFF = 4'h0;
  localparam logic [3:0] TIMER_OFF = 4'h4;
  localparam logic [31:0] DEF_RAM_BASE = 32'h0001_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'h0002_0000;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: combinational region decode of a core byte address into ROM/RAM/MMIO hits
module mem_addr_decode #(
  parameter int unsigned ROM_WORDS = 256,
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter logic [31:0] MMIO_BASE = 32'h0002_0000
) (
  input  logic [31:0] addr,
  output logic        rom_hit,
  output logic        ram_hit,
  output logic        mmio_hit,
  output logic        unmapped,
  output logic [21:0] ram_addr
);
  localparam logic [31:0] ROM_BYTES = ROM_WORDS * 4;
  localparam logic [31:0] RAM_BYTES = RAM_WORDS * 4;
  logic [31:0] ram_off;
  // addresses below RAM_BASE wrap to huge offsets, so a single compare bounds both ends
  assign ram_off = addr - RAM_BASE;
  assign rom_hit = addr < ROM_BYTES;
  assign ram_hit = ram_off < RAM_BYTES;
  assign mmio_hit = addr[31:4] == MMIO_BASE[31:4];
  assign unmapped = !(rom_hit || ram_hit || mmio_hit);
  assign ram_addr = ram_off[23:2];
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: core memory port bridge to ROM, sync RAM and MMIO page; optional timer via MEM_BUS_CTRL_TIMER_EN
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 256,
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [3:0]  ram_wen,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  leds,
  output logic        bus_err
);
  state_t state;
  logic rom_hit, ram_hit, mmio_hit, unmapped, wr, accept;
  logic [3:0] moff;
  logic [31:0] timer_rd, mmio_rd, resp_data;

  mem_addr_decode #(
    .ROM_WORDS(ROM_WORDS),
    .RAM_WORDS(RAM_WORDS),
    .RAM_BASE(RAM_BASE),
    .MMIO_BASE(MMIO_BASE)
  ) u_dec (
    .addr(mem_addr),
    .rom_hit(rom_hit),
    .ram_hit(ram_hit),
    .mmio_hit(mmio_hit),
    .unmapped(unmapped),
    .ram_addr(ram_addr)
  );

  assign wr = mem_wstrb != 4'h0;
  assign accept = state == IDLE && mem_valid;
  assign moff = {mem_addr[3:2], 2'b00};
  assign rom_addr = mem_addr;
  assign ram_wdata = mem_wdata;
  // write enables only in the accepting cycle, so each transaction writes at most once
  assign ram_wen = (accept && ram_hit && resetn) ? mem_wstrb : 4'h0;

`ifdef MEM_BUS_CTRL_TIMER_EN
  logic [31:0] timer;
  logic timer_clr;
  assign timer_clr = accept && mmio_hit && wr && moff == TIMER_OFF;
  // free-running cycle counter; reads see the value held before the accepting edge
  always_ff @(posedge clk)
    timer <= (!resetn || timer_clr) ? 32'h0 : timer + 32'h1;
  assign timer_rd = timer;
`else
  assign timer_rd = 32'h0;
`endif

  assign mmio_rd = moff == LED_OFF ? {24'h0, leds} : moff == TIMER_OFF ? timer_rd : 32'h0;
  assign resp_data = wr ? 32'h0 : rom_hit ? rom_data : mmio_hit ? mmio_rd : unmapped ? ERR_DATA : 32'h0;

  // transaction FSM: accept in IDLE, wait one cycle for RAM reads, pulse ready in RESP
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      leds <= 8'h0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_valid) begin
          if (ram_hit && !wr) state <= RAM_WAIT;
          else begin
            state <= RESP;
            mem_ready <= 1'b1;
            mem_rdata <= resp_data;
          end
          if (mmio_hit && moff == LED_OFF && mem_wstrb[0]) leds <= mem_wdata[7:0];
          if (unmapped || (rom_hit && wr)) bus_err <= 1'b1;
        end
        RAM_WAIT: begin
          state <= RESP;
          mem_ready <= 1'b1;
          mem_rdata <= ram_rdata;
        end
        default: begin
          state <= IDLE;
          mem_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
